// File: rtl/pulsegen_seq.sv
// -----------------------------------------------------------------------------
// pulsegen_seq
//
// Pulse generator for the DAC AXIS path. A table of up to NWORDS parallel-sample
// words lives in on-chip RAM. On start, the first len words are played as one
// pulse, followed by a gap of `wait` zero words. This repeats for a fixed number
// of repetitions, or for as long as start stays high when the count is 0. The
// output is a continuous AXIS stream: zero words are sent outside pulses, and
// m_axis_tready back-pressure freezes the whole pipeline.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   start              hardware start (already in the aclk domain)
//   mem_we/addr/wdata  table write port, usable at any time
//   m_axis_*           AXIS master: tvalid, tdata (N lanes of B bits), tlast
//   busy               FSM is not idle (registered with the state)
//   done               one-cycle pulse when a counted run completes
//   START_REG          software start (resynchronised)
//   START_SRC_REG      0: software start, 1: hardware start (resynchronised)
//   LEN_REG            pulse length in words (0 -> 1, clamped to NWORDS)
//   WAIT_REG           zero words between pulses
//   NREP_REG           repetition count, 0 = continuous
//
// Pipeline
//   p0  FSM state and table read address
//   p1  RAM read data plus "table word" and "last word" flags
//   p2  AXIS output register
// -----------------------------------------------------------------------------
module pulsegen_seq #(
    parameter  int N      = 16,
    parameter  int B      = 16,
    parameter  int NWORDS = 8,
    localparam int AW     = $clog2(NWORDS),
    localparam int W      = N * B
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_wdata,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic [W-1:0]  m_axis_tdata,
    output logic          m_axis_tlast,
    output logic          busy,
    output logic          done,
    input  logic          START_REG,
    input  logic          START_SRC_REG,
    input  logic [AW:0]   LEN_REG,
    input  logic [31:0]   WAIT_REG,
    input  logic [15:0]   NREP_REG
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_WAIT,
        S_DONE
    } state_t;

    // Convert a requested length into a last-address value: 0 plays a single
    // word, and anything longer than the table plays the whole table.
    function automatic logic [AW-1:0] clamp_len_m1(input logic [AW:0] len_req);
        logic [AW:0] tmp;
        if (len_req == '0) begin
            tmp = '0;
        end else if (len_req > (AW+1)'(NWORDS)) begin
            tmp = (AW+1)'(NWORDS - 1);
        end else begin
            tmp = len_req - (AW+1)'(1);
        end
        return tmp[AW-1:0];
    endfunction

    logic          start_reg_r1, start_reg_r2;
    logic          start_src_r1, start_src_r2;
    logic          start_mux;
    logic          en;

    state_t        state_p0, state_nxt;
    logic [AW-1:0] addr_p0, addr_nxt;
    logic [AW-1:0] len_m1, len_m1_nxt;
    logic [31:0]   wait_len, wait_nxt;
    logic [15:0]   nrep, nrep_nxt;
    logic [15:0]   rep_cnt, rep_nxt, rep_inc;
    logic [31:0]   wait_cnt, wcnt_nxt;
    logic          done_set;
    logic          issue_p0, last_p0;

    logic [W-1:0]  mem [NWORDS];
    logic [W-1:0]  rd_data_p1;
    logic          vld_p1, last_p1;

    logic [W-1:0]  tdata_p2;
    logic          tlast_p2;
    logic          tvalid_r;
    logic          busy_r;
    logic          done_r;

    // Register-interface start controls come from a slower domain and are
    // resynchronised. The hardware start is already aclk-synchronous and is
    // used directly, which keeps its start-to-data latency fixed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_reg_r1 <= 1'b0;
            start_reg_r2 <= 1'b0;
            start_src_r1 <= 1'b0;
            start_src_r2 <= 1'b0;
        end else begin
            start_reg_r1 <= START_REG;
            start_reg_r2 <= start_reg_r1;
            start_src_r1 <= START_SRC_REG;
            start_src_r2 <= start_src_r1;
        end
    end

    assign start_mux = start_src_r2 ? start : start_reg_r2;

    // The pipeline advances while the output is being accepted, or before the
    // stream has become valid at all.
    assign en = m_axis_tready | ~m_axis_tvalid;

    // ---- p0: sequencer FSM and table address ----
    assign issue_p0 = (state_p0 == S_PLAY);
    assign last_p0  = issue_p0 && (addr_p0 == len_m1);

    always_comb begin
        state_nxt  = state_p0;
        addr_nxt   = addr_p0;
        len_m1_nxt = len_m1;
        wait_nxt   = wait_len;
        nrep_nxt   = nrep;
        rep_nxt    = rep_cnt;
        wcnt_nxt   = wait_cnt;
        done_set   = 1'b0;
        rep_inc    = rep_cnt + 16'd1;

        case (state_p0)
            S_IDLE: begin
                if (start_mux) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                len_m1_nxt = clamp_len_m1(LEN_REG);
                wait_nxt   = WAIT_REG;
                nrep_nxt   = NREP_REG;
                addr_nxt   = '0;
                rep_nxt    = '0;
                wcnt_nxt   = '0;
                state_nxt  = S_PLAY;
            end
            S_PLAY: begin
                if (addr_p0 == len_m1) begin
                    rep_nxt  = rep_inc;
                    addr_nxt = '0;
                    wcnt_nxt = '0;
                    if ((nrep != 16'd0) && (rep_inc == nrep)) begin
                        state_nxt = S_DONE;
                        done_set  = 1'b1;
                    end else if ((nrep == 16'd0) && !start_mux) begin
                        state_nxt = S_IDLE;
                    end else if (wait_len == 32'd0) begin
                        state_nxt = S_PLAY;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else begin
                    addr_nxt = addr_p0 + AW'(1);
                end
            end
            S_WAIT: begin
                if (wait_cnt == wait_len - 32'd1) begin
                    state_nxt = S_PLAY;
                    addr_nxt  = '0;
                end else begin
                    wcnt_nxt = wait_cnt + 32'd1;
                end
            end
            S_DONE: begin
                // Hold here until start drops so a held start cannot retrigger.
                if (!start_mux) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_p0 <= S_IDLE;
            addr_p0  <= '0;
            len_m1   <= '0;
            wait_len <= '0;
            nrep     <= '0;
            rep_cnt  <= '0;
            wait_cnt <= '0;
            busy_r   <= 1'b0;
        end else if (en) begin
            state_p0 <= state_nxt;
            addr_p0  <= addr_nxt;
            len_m1   <= len_m1_nxt;
            wait_len <= wait_nxt;
            nrep     <= nrep_nxt;
            rep_cnt  <= rep_nxt;
            wait_cnt <= wcnt_nxt;
            busy_r   <= (state_nxt != S_IDLE);
        end
    end

    // done is rebuilt every cycle so it can never stretch across a stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_r <= 1'b0;
        end else begin
            done_r <= en & done_set;
        end
    end

    // ---- p1: table RAM read ----
    // Simple dual-port table: the write side ignores back-pressure, the read
    // side follows the pipeline enable. Contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (en) begin
            rd_data_p1 <= mem[addr_p0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= issue_p0;
            last_p1 <= last_p0;
        end
    end

    // ---- p2: AXIS output register ----
    // The read data is only meaningful for issued table words, so it is
    // replaced by zero everywhere else.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_p2 <= '0;
            tlast_p2 <= 1'b0;
        end else if (en) begin
            tdata_p2 <= vld_p1 ? rd_data_p1 : '0;
            tlast_p2 <= vld_p1 & last_p1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= 1'b1;
        end
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_p2;
    assign m_axis_tlast  = tlast_p2;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_pulsegen_seq.sv
// -----------------------------------------------------------------------------
// tb_pulsegen_seq
//
// Directed bench for pulsegen_seq (N=16, B=16, NWORDS=8). Table word w holds
// sample value 16*w + lane in every lane. Expected stream values are written
// out per cycle relative to the cycle in which start is raised.
// -----------------------------------------------------------------------------
module tb_pulsegen_seq;

    localparam int N  = 16;
    localparam int B  = 16;
    localparam int NW = 8;
    localparam int AW = 3;
    localparam int W  = N * B;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          m_axis_tready;
    logic          m_axis_tvalid;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic          START_REG;
    logic          START_SRC_REG;
    logic [AW:0]   LEN_REG;
    logic [31:0]   WAIT_REG;
    logic [15:0]   NREP_REG;

    int n_chk = 0;
    int n_bad = 0;

    pulsegen_seq #(.N(N), .B(B), .NWORDS(NW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .START_REG     (START_REG),
        .START_SRC_REG (START_SRC_REG),
        .LEN_REG       (LEN_REG),
        .WAIT_REG      (WAIT_REG),
        .NREP_REG      (NREP_REG)
    );

    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] wv(input int w);
        logic [W-1:0] r;
        for (int l = 0; l < N; l++) begin
            r[l*B +: B] = 16'(16 * w + l);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Pulse start for one cycle and follow a counted run of n words.
    task automatic run_pulse(input int n, input string tag);
        start = 1'b1;
        for (int i = 1; i <= n + 5; i++) begin
            step();
            if (i == 1) start = 1'b0;
            if (i >= 4 && i < 4 + n) begin
                chk($sformatf("%s data %0d", tag, i), m_axis_tdata, wv(i - 4));
                chk($sformatf("%s last %0d", tag, i), W'(m_axis_tlast), W'(i == 3 + n));
            end else begin
                chk($sformatf("%s zero %0d", tag, i), m_axis_tdata, '0);
                chk($sformatf("%s last %0d", tag, i), W'(m_axis_tlast), '0);
            end
            chk($sformatf("%s done %0d", tag, i), W'(done), W'(i == n + 2));
        end
    endtask

    initial begin
        int adv;
        int j;
        logic rdy_prev;
        logic [W-1:0] exp_d;
        logic exp_l;

        aresetn       = 1'b0;
        start         = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        m_axis_tready = 1'b1;
        START_REG     = 1'b0;
        START_SRC_REG = 1'b0;
        LEN_REG       = '0;
        WAIT_REG      = '0;
        NREP_REG      = '0;

        // Reset state
        step();
        step();
        chk("rst tvalid", W'(m_axis_tvalid), '0);
        chk("rst tdata", m_axis_tdata, '0);
        chk("rst tlast", W'(m_axis_tlast), '0);
        chk("rst busy", W'(busy), '0);
        chk("rst done", W'(done), '0);
        aresetn = 1'b1;
        step();
        chk("post-rst tvalid", W'(m_axis_tvalid), W'(1));
        chk("post-rst tdata", m_axis_tdata, '0);

        // Load table
        for (int w = 0; w < NW; w++) begin
            mem_we    = 1'b1;
            mem_addr  = AW'(w);
            mem_wdata = wv(w);
            step();
        end
        mem_we = 1'b0;

        // Test 1: LEN=4 WAIT=0 NREP=2, hardware start pulse
        START_SRC_REG = 1'b1;
        LEN_REG       = 4'd4;
        WAIT_REG      = 32'd0;
        NREP_REG      = 16'd2;
        step(); step(); step();
        start = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 1) start = 1'b0;
            if (i >= 4 && i <= 11) begin
                exp_d = wv((i - 4) % 4);
                exp_l = ((i - 4) % 4 == 3);
            end else begin
                exp_d = '0;
                exp_l = 1'b0;
            end
            chk($sformatf("t1 data %0d", i), m_axis_tdata, exp_d);
            chk($sformatf("t1 last %0d", i), W'(m_axis_tlast), W'(exp_l));
            chk($sformatf("t1 done %0d", i), W'(done), W'(i == 10));
            chk($sformatf("t1 busy %0d", i), W'(busy), W'(i <= 10));
            chk($sformatf("t1 tvalid %0d", i), W'(m_axis_tvalid), W'(1));
        end

        // Test 2: LEN=2 WAIT=3 continuous from START_REG, then cleared
        START_SRC_REG = 1'b0;
        LEN_REG       = 4'd2;
        WAIT_REG      = 32'd3;
        NREP_REG      = 16'd0;
        step(); step(); step();
        START_REG = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            exp_d = '0;
            exp_l = 1'b0;
            if (i >= 6 && i <= 27) begin
                if ((i - 6) % 5 == 0) exp_d = wv(0);
                if ((i - 6) % 5 == 1) begin
                    exp_d = wv(1);
                    exp_l = 1'b1;
                end
            end
            chk($sformatf("t2 data %0d", i), m_axis_tdata, exp_d);
            chk($sformatf("t2 last %0d", i), W'(m_axis_tlast), W'(exp_l));
            chk($sformatf("t2 busy %0d", i), W'(busy), W'(i >= 3 && i <= 25));
            if (i == 21) START_REG = 1'b0;
        end

        // Test 3: length clamping
        START_SRC_REG = 1'b1;
        WAIT_REG      = 32'd0;
        NREP_REG      = 16'd1;
        LEN_REG       = 4'd0;
        step(); step(); step();
        run_pulse(1, "t3 len0");
        LEN_REG = 4'(NW + 5);
        step();
        run_pulse(NW, "t3 lenbig");

        // Test 4: 5-cycle back-pressure mid-pulse, LEN=4 WAIT=2 NREP=2
        LEN_REG  = 4'd4;
        WAIT_REG = 32'd2;
        NREP_REG = 16'd2;
        step();
        adv   = 0;
        start = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            rdy_prev = m_axis_tready;
            step();
            if (rdy_prev) adv++;
            j     = adv - 4;
            exp_d = '0;
            exp_l = 1'b0;
            if (j >= 0 && j / 6 < 2 && j % 6 < 4) begin
                exp_d = wv(j % 6);
                exp_l = (j % 6 == 3);
            end
            chk($sformatf("t4 data %0d", i), m_axis_tdata, exp_d);
            chk($sformatf("t4 last %0d", i), W'(m_axis_tlast), W'(exp_l));
            if (i == 1) start = 1'b0;
            m_axis_tready = !(i >= 6 && i <= 10);
        end
        m_axis_tready = 1'b1;

        // Test 5: asynchronous reset mid-pulse, then replay
        LEN_REG  = 4'd8;
        WAIT_REG = 32'd0;
        NREP_REG = 16'd1;
        step();
        start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) start = 1'b0;
        end
        chk("t5 pre-rst data", m_axis_tdata, wv(2));
        aresetn = 1'b0;
        #1;
        chk("t5 rst tdata", m_axis_tdata, '0);
        chk("t5 rst tvalid", W'(m_axis_tvalid), '0);
        chk("t5 rst tlast", W'(m_axis_tlast), '0);
        chk("t5 rst busy", W'(busy), '0);
        step(); step();
        aresetn = 1'b1;
        step(); step(); step(); step();
        chk("t5 idle tvalid", W'(m_axis_tvalid), W'(1));
        chk("t5 idle tdata", m_axis_tdata, '0);
        chk("t5 idle busy", W'(busy), '0);
        run_pulse(NW, "t5 replay");

        // Test 6: NREP=1 with start held after done
        LEN_REG  = 4'd2;
        NREP_REG = 16'd1;
        step();
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_d = (i == 4) ? wv(0) : (i == 5) ? wv(1) : '0;
            chk($sformatf("t6 data %0d", i), m_axis_tdata, exp_d);
            chk($sformatf("t6 last %0d", i), W'(m_axis_tlast), W'(i == 5));
            chk($sformatf("t6 done %0d", i), W'(done), W'(i == 4));
            chk($sformatf("t6 busy %0d", i), W'(busy), W'(1));
        end
        start = 1'b0;
        step();
        chk("t6 release busy", W'(busy), '0);
        run_pulse(2, "t6 again");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
